// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a two-stage pixel pipeline for the Snake display path.
// Define VGA_TEST_PATTERN_EN to build in the eight-bar colour test pattern.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 29,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned COLOUR_W = 12
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [COLOUR_W-1:0]         COLOUR_IN,
  input  logic                        PATTERN_SEL,
  output logic                        PIX_EN,
  output logic [$clog2(H_ACTIVE)-1:0] ADDRH,
  output logic [$clog2(V_ACTIVE)-1:0] ADDRV,
  output logic                        HS,
  output logic                        VS,
  output logic                        DE,
  output logic [COLOUR_W-1:0]         COLOUR_OUT,
  output logic                        VBLANK_START
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned AH_W    = $clog2(H_ACTIVE);
  localparam int unsigned AV_W    = $clog2(V_ACTIVE);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        HS_ON   = (HS_POL != 0);
  localparam logic        VS_ON   = (VS_POL != 0);

  logic [DIV_W-1:0]    div_q, div_d;
  logic                pix_en_q, pix_en_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic [VC_W-1:0]     vc_q, vc_d;
  logic [31:0]         hc_w, vc_w;
  logic                h_wrap, v_wrap, h_vis, v_vis, hs_act, vs_act, vis;
  logic [AH_W-1:0]     addrh_q, addrh_d;
  logic [AV_W-1:0]     addrv_q, addrv_d;
  logic                hs1_q, vs1_q, de1_q;
  logic                hs_q, vs_q, de_q;
  logic [COLOUR_W-1:0] colour_q, colour_src;

  always_comb begin
    hc_w     = 32'(hc_q);
    vc_w     = 32'(vc_q);
    div_d    = (32'(div_q) == CLK_DIV - 1) ? '0 : div_q + DIV_W'(1);
    // Registered strobe so PIX_EN is low during reset even when CLK_DIV is 1.
    pix_en_d = (32'(div_d) == CLK_DIV - 1);
    h_wrap   = (hc_w == H_TOTAL - 1);
    v_wrap   = (vc_w == V_TOTAL - 1);
    hc_d     = h_wrap ? '0 : hc_q + HC_W'(1);
    vc_d     = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + VC_W'(1);
    end
    h_vis    = (hc_w >= H_START) && (hc_w < H_START + H_ACTIVE);
    v_vis    = (vc_w >= V_START) && (vc_w < V_START + V_ACTIVE);
    vis      = h_vis && v_vis;
    hs_act   = (hc_w < H_SYNC);
    vs_act   = (vc_w < V_SYNC);
    addrh_d  = vis ? AH_W'(hc_w - H_START) : '0;
    addrv_d  = vis ? AV_W'(vc_w - V_START) : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned FIELD_W = COLOUR_W / 3;

  logic [2:0]          bar_idx;
  logic [COLOUR_W-1:0] bar_colour;

  // Bar index follows the stage-1 address, which is aligned with de1.
  always_comb begin
    bar_idx    = 3'(32'(addrh_q) * 8 / H_ACTIVE);
    bar_colour = '0;
    bar_colour[3*FIELD_W-1 -: FIELD_W] = {FIELD_W{bar_idx[2]}};
    bar_colour[2*FIELD_W-1 -: FIELD_W] = {FIELD_W{bar_idx[1]}};
    bar_colour[FIELD_W-1:0]            = {FIELD_W{bar_idx[0]}};
  end

  assign colour_src = PATTERN_SEL ? bar_colour : COLOUR_IN;
`else
  logic unused_pattern_sel;

  assign unused_pattern_sel = PATTERN_SEL;
  assign colour_src         = COLOUR_IN;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      addrh_q  <= '0;
      addrv_q  <= '0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      de1_q    <= 1'b0;
      hs_q     <= ~HS_ON;
      vs_q     <= ~VS_ON;
      de_q     <= 1'b0;
      colour_q <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      if (pix_en_q) begin
        hc_q     <= hc_d;
        vc_q     <= vc_d;
        addrh_q  <= addrh_d;
        addrv_q  <= addrv_d;
        hs1_q    <= hs_act;
        vs1_q    <= vs_act;
        de1_q    <= vis;
        hs_q     <= hs1_q ? HS_ON : ~HS_ON;
        vs_q     <= vs1_q ? VS_ON : ~VS_ON;
        de_q     <= de1_q;
        colour_q <= de1_q ? colour_src : '0;
      end
    end
  end

  assign PIX_EN       = pix_en_q;
  assign ADDRH        = addrh_q;
  assign ADDRV        = addrv_q;
  assign HS           = hs_q;
  assign VS           = vs_q;
  assign DE           = de_q;
  assign COLOUR_OUT   = colour_q;
  assign VBLANK_START = pix_en_q && (hc_w == 0) && (vc_w == V_START + V_ACTIVE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default-mode reset, a short-frame mode for full-frame checks,
// and an 800-pixel CLK_DIV=1 high-active variant.
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic pattern_sel;

  // Short-frame instance: default horizontal timing, 11-line frame.
  logic        pix_en_m, hs_m, vs_m, de_m, vblank_m;
  logic [9:0]  addrh_m;
  logic [1:0]  addrv_m;
  logic [11:0] colour_in_m, colour_out_m;
  assign colour_in_m = {2'b00, addrv_m, addrh_m[7:0]};

  vga_timing_gen #(
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(4), .V_FRONT(2)
  ) u_dut_m (
    .CLK(clk), .RESET(reset_n), .COLOUR_IN(colour_in_m), .PATTERN_SEL(pattern_sel),
    .PIX_EN(pix_en_m), .ADDRH(addrh_m), .ADDRV(addrv_m), .HS(hs_m), .VS(vs_m), .DE(de_m),
    .COLOUR_OUT(colour_out_m), .VBLANK_START(vblank_m)
  );

  // Fully default instance.
  logic        pix_en_df, hs_df, vs_df, de_df, vblank_df;
  logic [9:0]  addrh_df;
  logic [8:0]  addrv_df;
  logic [11:0] colour_in_df, colour_out_df;
  assign colour_in_df = {addrv_df[3:0], addrh_df[7:0]};

  vga_timing_gen u_dut_df (
    .CLK(clk), .RESET(reset_n), .COLOUR_IN(colour_in_df), .PATTERN_SEL(pattern_sel),
    .PIX_EN(pix_en_df), .ADDRH(addrh_df), .ADDRV(addrv_df), .HS(hs_df), .VS(vs_df), .DE(de_df),
    .COLOUR_OUT(colour_out_df), .VBLANK_START(vblank_df)
  );

  // Variant: CLK_DIV=1, 800 active of 1056, high-active HS.
  logic        pix_en_v, hs_v, vs_v, de_v, vblank_v;
  logic [9:0]  addrh_v;
  logic [1:0]  addrv_v;
  logic [11:0] colour_in_v, colour_out_v;
  assign colour_in_v = {2'b00, addrh_v};

  vga_timing_gen #(
    .CLK_DIV(1), .H_SYNC(128), .H_BACK(88), .H_ACTIVE(800), .H_FRONT(40),
    .V_SYNC(2), .V_BACK(3), .V_ACTIVE(4), .V_FRONT(2), .HS_POL(1)
  ) u_dut_v (
    .CLK(clk), .RESET(reset_n), .COLOUR_IN(colour_in_v), .PATTERN_SEL(pattern_sel),
    .PIX_EN(pix_en_v), .ADDRH(addrh_v), .ADDRV(addrv_v), .HS(hs_v), .VS(vs_v), .DE(de_v),
    .COLOUR_OUT(colour_out_v), .VBLANK_START(vblank_v)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam int FRAME_END_S = 4 * 8801 + 3;  // last sample showing output pixel 8799
  localparam int RST_S       = 55600;         // second frame, line 6, inside the visible area

  int pix_rst, mis_m, mis_df, mis_v;
  int vb_cnt, vb_s, vs_tot, col_leak, hs_cnt, de_cnt, hsv_cnt;
  int max_ah, max_av, max_ahv;
  int p, g, ln, hcx, gv;
  logic [31:0] exp_first, exp_last;

  initial begin
    reset_n     = 1'b0;
    pattern_sel = 1'b0;
    pix_rst = 0; mis_m = 0; mis_df = 0; mis_v = 0;
    vb_cnt = 0; vb_s = -1; vs_tot = 0; col_leak = 0; hs_cnt = 0; de_cnt = 0; hsv_cnt = 0;
    max_ah = 0; max_av = 0; max_ahv = 0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (pix_en_m || pix_en_df || pix_en_v) pix_rst++;
    end
    check_val("rst_no_pix_en", 32'(pix_rst), 32'd0);
    check_val("rst_hs", 32'(hs_df), 32'd1);
    check_val("rst_vs", 32'(vs_df), 32'd1);
    check_val("rst_de", 32'(de_df), 32'd0);
    check_val("rst_colour", 32'(colour_out_df), 32'd0);
    check_val("rst_addrh", 32'(addrh_df), 32'd0);
    check_val("rst_addrv", 32'(addrv_df), 32'd0);
    check_val("rst_vblank", 32'(vblank_df), 32'd0);
    check_val("rst_hs_variant", 32'(hs_v), 32'd0);

    reset_n = 1'b1;
    for (int s = 1; s <= RST_S; s++) begin
      @(posedge clk); #1;
      if (pix_en_m !== (s % 4 == 3)) mis_m++;
      if (pix_en_df !== (s % 4 == 3)) mis_df++;
      if (pix_en_v !== 1'b1) mis_v++;
      if (vblank_m) begin
        vb_cnt++;
        vb_s = s;
      end
      if (32'(addrh_v) > 32'(max_ahv)) max_ahv = int'(addrh_v);

      // Outputs at pixel-strobe sample p show output pixel p-2.
      if (s % 4 == 3 && s <= FRAME_END_S) begin
        p = (s - 3) / 4;
        if (32'(addrh_m) > 32'(max_ah)) max_ah = int'(addrh_m);
        if (32'(addrv_m) > 32'(max_av)) max_av = int'(addrv_m);
        if (p >= 2) begin
          g   = p - 2;
          ln  = g / 800;
          hcx = g % 800;
          if (!hs_m) hs_cnt++;
          if (!vs_m) vs_tot++;
          if (de_m) begin
            de_cnt++;
            exp_first = (PAT && ln == 8) ? 32'h000 : 32'((ln - 5) << 8);
            exp_last  = (PAT && ln == 8) ? 32'hFFF : 32'(((ln - 5) << 8) | 'h7F);
            if (de_cnt == 1)
              check_val($sformatf("first_de_colour_line%0d", ln), 32'(colour_out_m), exp_first);
            if (de_cnt == 640)
              check_val($sformatf("last_de_colour_line%0d", ln), 32'(colour_out_m), exp_last);
          end else if (colour_out_m != 12'h000) begin
            col_leak++;
          end
          if (hcx == 799) begin
            check_val($sformatf("hs_low_line%0d", ln), 32'(hs_cnt), 32'd96);
            check_val($sformatf("de_count_line%0d", ln), 32'(de_cnt),
                      (ln >= 5 && ln <= 8) ? 32'd640 : 32'd0);
            hs_cnt = 0;
            de_cnt = 0;
          end
          if (g == 6395) pattern_sel = PAT;
          if (g == 7195) pattern_sel = 1'b0;
        end
      end

      // Variant: one pixel per CLK, output pixel s-3.
      if (s >= 3 && s - 3 < 2112) begin
        gv = s - 3;
        if (hs_v) hsv_cnt++;
        if (gv % 1056 == 1055) begin
          check_val($sformatf("variant_hs_high_line%0d", gv / 1056), 32'(hsv_cnt), 32'd128);
          hsv_cnt = 0;
        end
      end
    end

    check_val("pix_en_period_short", 32'(mis_m), 32'd0);
    check_val("pix_en_period_default", 32'(mis_df), 32'd0);
    check_val("variant_pix_en_const", 32'(mis_v), 32'd0);
    check_val("vblank_pulses", 32'(vb_cnt), 32'd1);
    check_val("vblank_position", 32'(vb_s), 32'd28803);
    check_val("vs_low_pixels", 32'(vs_tot), 32'd1600);
    check_val("colour_outside_de", 32'(col_leak), 32'd0);
    check_val("addrh_max", 32'(max_ah), 32'd639);
    check_val("addrv_max", 32'(max_av), 32'd3);
    check_val("variant_addrh_max", 32'(max_ahv), 32'd799);
    check_val("pre_reset_de", 32'(de_m), 32'd1);

    // One-cycle reset in the middle of a visible line.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_val("midrst_hs", 32'(hs_m), 32'd1);
    check_val("midrst_vs", 32'(vs_m), 32'd1);
    check_val("midrst_de", 32'(de_m), 32'd0);
    check_val("midrst_colour", 32'(colour_out_m), 32'd0);
    check_val("midrst_addrh", 32'(addrh_m), 32'd0);
    check_val("midrst_addrv", 32'(addrv_m), 32'd0);
    check_val("midrst_pix_en", 32'(pix_en_m), 32'd0);
    check_val("midrst_vblank", 32'(vblank_m), 32'd0);
    check_val("midrst_variant_hs", 32'(hs_v), 32'd0);
    for (int s = 1; s <= 8; s++) begin
      @(posedge clk); #1;
      if (s == 2) check_val("restart_pix_en_s2", 32'(pix_en_m), 32'd0);
      if (s == 3) check_val("restart_pix_en_s3", 32'(pix_en_m), 32'd1);
      if (s == 7) check_val("restart_hs_s7", 32'(hs_m), 32'd1);
      if (s == 8) begin
        check_val("restart_hs_s8", 32'(hs_m), 32'd0);
        check_val("restart_vs_s8", 32'(vs_m), 32'd0);
        check_val("restart_de_s8", 32'(de_m), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
